// File: rtl/lsu_mem_port.sv
// lsu_mem_port: RV32I load/store unit in front of a byte-addressed data memory.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/HU/W accesses are
// rejected with resp_err instead of reaching memory.
module lsu_mem_port #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_byte_enable,
    inout  logic [31:0]           mem_data
);

    localparam int unsigned DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    write_q, write_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    mem_drive_q, mem_drive_d;

    logic                    req_ready_d;
    logic                    resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_d;
    logic                    resp_err_d;
    logic                    mem_enable_d;
    logic                    mem_write_enable_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [1:0]              mem_byte_enable_d;

    logic                    accept_c;
    logic                    illegal_c;
    logic                    misalign_c;
    logic                    unused_addr_c;

    // Upper request address bits are outside the memory and intentionally dropped
    assign unused_addr_c = ^req_addr[31:ADDR_WIDTH];

    // Store data is on the bus only while the store access strobe is up
    assign mem_data = mem_drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

    assign accept_c = req_valid && (state_q == IDLE);

    // Legal width codes: loads B/H/W/BU/HU, stores B/H/W
    always_comb begin
        illegal_c = 1'b0;
        if (req_write) begin
            illegal_c = (req_funct3[2] || (req_funct3[1:0] == 2'b11));
        end else begin
            illegal_c = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Halfword needs an even address, word needs a 4-byte aligned address
    always_comb begin
        misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    end
`else
    // Misaligned accesses go to memory unchanged
    always_comb begin
        misalign_c = 1'b0;
    end
`endif

    // Extend captured load data according to the latched width code
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [2:0] f3,
                                                          input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b100:  r = {24'h0, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b101:  r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Next state, latched request fields and next values of every registered output
    always_comb begin
        state_d            = state_q;
        write_d            = write_q;
        funct3_d           = funct3_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        resp_err_d         = 1'b0;
        resp_rdata_d       = '0;
        mem_byte_enable_d  = 2'b00;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr[ADDR_WIDTH-1:0];
                    wdata_d  = req_wdata;
                    if (illegal_c || misalign_c) begin
                        state_d    = RESP;
                        resp_err_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                state_d = write_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_d      = RESP;
                resp_rdata_d = extend_load(funct3_q, mem_data);
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    resp_err_d   = resp_err;
                    resp_rdata_d = resp_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d        = (state_d == IDLE);
        resp_valid_d       = (state_d == RESP);
        mem_enable_d       = (state_d == ACCESS);
        mem_write_enable_d = (state_d == ACCESS) && write_d;
        mem_drive_d        = (state_d == ACCESS) && write_d;
        mem_addr_d         = (state_d == ACCESS) ? addr_d : '0;

        if (state_d == ACCESS) begin
            if (write_d) begin
                case (funct3_d[1:0])
                    2'b00:   mem_byte_enable_d = 2'b00;
                    2'b01:   mem_byte_enable_d = 2'b01;
                    default: mem_byte_enable_d = 2'b11;
                endcase
            end else begin
                mem_byte_enable_d = 2'b11;
            end
        end
    end

    // State, request latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            funct3_q         <= 3'b000;
            addr_q           <= '0;
            wdata_q          <= '0;
            mem_drive_q      <= 1'b0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_err         <= 1'b0;
            mem_enable       <= 1'b0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_byte_enable  <= 2'b00;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            funct3_q         <= funct3_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            mem_drive_q      <= mem_drive_d;
            req_ready        <= req_ready_d;
            resp_valid       <= resp_valid_d;
            resp_rdata       <= resp_rdata_d;
            resp_err         <= resp_err_d;
            mem_enable       <= mem_enable_d;
            mem_write_enable <= mem_write_enable_d;
            mem_addr         <= mem_addr_d;
            mem_byte_enable  <= mem_byte_enable_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port against a 256-byte memory model.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_enable;
    logic        mem_write_enable;
    logic [7:0]  mem_addr;
    logic [1:0]  mem_byte_enable;
    tri   [31:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state
    logic [7:0]  mem [256];
    logic        rd_en;
    logic [31:0] rd_data;
    logic        tb_drv;
    int          acc_total;
    logic        acc_we;
    logic [7:0]  acc_addr;
    logic [1:0]  acc_be;
    logic [31:0] acc_bus;

    lsu_mem_port #(.ADDR_WIDTH(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_enable       (mem_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_byte_enable  (mem_byte_enable),
        .mem_data         (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data = rd_en  ? rd_data      : 32'bz;
    assign mem_data = tb_drv ? 32'h5A5A5A5A : 32'bz;

    // Byte memory with registered read; addr+k wraps modulo 256
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            rd_en   <= 1'b0;
            rd_data <= 32'h0;
        end else begin
            rd_en <= 1'b0;
            if (mem_enable) begin
                acc_total <= acc_total + 1;
                acc_we    <= mem_write_enable;
                acc_addr  <= mem_addr;
                acc_be    <= mem_byte_enable;
                acc_bus   <= mem_data;
                if (mem_write_enable) begin
                    mem[mem_addr] <= mem_data[7:0];
                    if (mem_byte_enable != 2'b00) mem[mem_addr + 8'd1] <= mem_data[15:8];
                    if (mem_byte_enable == 2'b11) begin
                        mem[mem_addr + 8'd2] <= mem_data[23:16];
                        mem[mem_addr + 8'd3] <= mem_data[31:24];
                    end
                end else begin
                    rd_en   <= 1'b1;
                    rd_data <= {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                                mem[mem_addr + 8'd1], mem[mem_addr]};
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request/response transaction with hand-computed expectations
    task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int exp_lat, input logic [1:0] exp_be, input int hold);
        int lat;
        int a0;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        a0 = acc_total;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " err"}, 32'(resp_err), 32'(exp_err));
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " mem_enable idle"}, 32'(mem_enable), 32'd0);
        if (exp_err) begin
            check({tag, " no access"}, 32'(acc_total - a0), 32'd0);
        end else begin
            check({tag, " one access"}, 32'(acc_total - a0), 32'd1);
            check({tag, " we"}, 32'(acc_we), 32'(wr));
            check({tag, " addr"}, 32'(acc_addr), 32'(addr[7:0]));
            check({tag, " be"}, 32'(acc_be), 32'(exp_be));
            if (wr) check({tag, " bus"}, acc_bus, wdata);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold valid"}, 32'(resp_valid), 32'd1);
            check({tag, " hold err"}, 32'(resp_err), 32'(exp_err));
            check({tag, " hold rdata"}, resp_rdata, exp_rdata);
            check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
            check({tag, " hold mem_enable"}, 32'(mem_enable), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check({tag, " valid drop"}, 32'(resp_valid), 32'd0);
        check({tag, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        tb_drv     = 1'b0;
        acc_total  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst resp_valid", 32'(resp_valid), 32'd0);
        check("rst mem_enable", 32'(mem_enable), 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset landing in the middle of a store ACCESS cycle
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("mid access enable", 32'(mem_enable), 32'd1);
        check("mid access write", 32'(mem_write_enable), 32'd1);
        #1 rst_n = 1'b0; tb_drv = 1'b1;
        #1;
        check("arst mem_enable", 32'(mem_enable), 32'd0);
        check("arst mem_we", 32'(mem_write_enable), 32'd0);
        check("arst mem_addr", 32'(mem_addr), 32'd0);
        check("arst mem_be", 32'(mem_byte_enable), 32'd0);
        check("arst resp_valid", 32'(resp_valid), 32'd0);
        check("arst resp_err", 32'(resp_err), 32'd0);
        check("arst bus released", mem_data, 32'h5A5A5A5A);
        tb_drv = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1 check("post rst req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 check("no stale resp", 32'(resp_valid), 32'd0);

        // Stores and loads of every width
        xact("SW 10",  1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 2'b11, 0);
        check("mem 10", 32'(mem[8'h10]), 32'hEF);
        check("mem 13", 32'(mem[8'h13]), 32'hDE);
        xact("LB 10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 3, 2'b11, 0);
        xact("LBU 10", 1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'h000000EF, 3, 2'b11, 0);
        xact("LH 10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF, 3, 2'b11, 0);
        xact("LHU 10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000BEEF, 3, 2'b11, 0);
        xact("LW 10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 2'b11, 2);
        xact("LBU hi", 1'b0, 3'b100, 32'h12340010, 32'h0, 1'b0, 32'h000000EF, 3, 2'b11, 0);
        xact("SB 20",  1'b1, 3'b000, 32'h20, 32'h12345678, 1'b0, 32'h0, 2, 2'b00, 0);
        xact("LW 20a", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h00000078, 3, 2'b11, 0);
        xact("SH 20",  1'b1, 3'b001, 32'h20, 32'h12345678, 1'b0, 32'h0, 2, 2'b01, 0);
        xact("LW 20b", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h00005678, 3, 2'b11, 0);

        // Illegal width codes
        xact("L f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 2'b00, 5);
        xact("L f3=110", 1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 1, 2'b00, 0);
        xact("S f3=100", 1'b1, 3'b100, 32'h30, 32'h11111111, 1'b1, 32'h0, 1, 2'b00, 0);
        check("mem 30 untouched", 32'(mem[8'h30]), 32'h00);

        // Wrap at the top of memory
        xact("SB FF", 1'b1, 3'b000, 32'hFF, 32'h00000099, 1'b0, 32'h0, 2, 2'b00, 0);
        xact("SB 00", 1'b1, 3'b000, 32'h00, 32'h00000088, 1'b0, 32'h0, 2, 2'b00, 0);
        xact("LBU FF", 1'b0, 3'b100, 32'hFF, 32'h0, 1'b0, 32'h00000099, 3, 2'b11, 0);

`ifdef MISALIGN_TRAP_EN
        xact("LW 13", 1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 32'h0, 1, 2'b00, 0);
        xact("LH FF", 1'b0, 3'b001, 32'hFF, 32'h0, 1'b1, 32'h0, 1, 2'b00, 0);
`else
        xact("LW 13", 1'b0, 3'b010, 32'h13, 32'h0, 1'b0, 32'h000000DE, 3, 2'b11, 0);
        xact("LH FF", 1'b0, 3'b001, 32'hFF, 32'h0, 1'b0, 32'hFFFF8899, 3, 2'b11, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store unit sitting directly upstream of the byte-addressed 256-byte data memory; the RISC-V execute stage sends it load/store requests.
- Translates RV32I funct3 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory enable/write/byte-enable cycles on the shared 32-bit bidirectional data bus.
- Sign/zero-extends load data and returns it through a valid/ready response channel.

Parameters:
ADDR_WIDTH, 8, memory byte-address width; mem_addr = req_addr[ADDR_WIDTH-1:0], upper request bits ignored

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte in bits 7:0
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data (0 for stores and errors)
resp_err  output  1  request was rejected, no memory access made
mem_enable  output  1  memory access strobe
mem_write_enable  output  1  memory write select
mem_addr  output  ADDR_WIDTH  memory byte address
mem_byte_enable  output  2  00 = byte, 01 = half, 11 = word
mem_data  inout  32  shared data bus, driven by this unit only during the store ACCESS cycle

Behaviour:
- Reset (async, immediate): state = IDLE; resp_valid/resp_err/mem_enable/mem_write_enable = 0; resp_rdata, mem_addr, mem_byte_enable = 0; mem_data = high-Z. Reset mid-operation abandons the access with no response.
- Accept on req_valid & req_ready; latch write, funct3, addr, wdata.
- Legal funct3: loads 000 B, 001 H, 010 W, 100 BU, 101 HU; stores 000/001/010 only. Any other code sets ERR.
- FSM IDLE -> ACCESS -> (load) CAPTURE -> RESP -> IDLE; (store) ACCESS -> RESP; (error) IDLE -> RESP with resp_err = 1.
- ACCESS, 1 cycle: mem_enable = 1, mem_addr and mem_byte_enable set. Byte-enable map: B = 00, H = 01, W = 11; loads use 11.
  - Store: mem_write_enable = 1 and mem_data driven with latched wdata this cycle only.
  - Load: mem_write_enable = 0 and the bus is released.
- CAPTURE: sample mem_data (memory's registered read, bytes addr..addr+3 in bits 7:0..31:24).
  - B: sign-extend [7:0]; BU: zero-extend [7:0].
  - H: sign-extend [15:0]; HU: zero-extend [15:0].
  - W: pass all 32 bits.
- RESP: resp_valid held with stable rdata/err until resp_ready; on handshake return to IDLE; req_ready goes high the following cycle (no same-cycle back-to-back).
- Latency from accept edge to resp_valid: load 3 cycles, store 2, error 1.
- All mem_* outputs are 0 outside ACCESS.
- Address wrap: accesses near 0xFF pass through unchanged; the memory wraps addr+k modulo 256.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: H/HU with addr[0] = 1, or W with addr[1:0] != 0, takes the ERR path (resp_err = 1, rdata = 0, no mem_enable pulse).
- Undefined: misaligned accesses proceed normally; resp_err only for illegal funct3.

Test Plan:
- Reset with mem_enable high mid-ACCESS -> all outputs 0 and mem_data Z in the same cycle; after release, req_ready = 1.
- SW addr 0x10 wdata 0xDEADBEEF -> one ACCESS cycle with mem_enable = 1, write = 1, byte_enable = 11, bus = 0xDEADBEEF; resp_valid 2 cycles after accept, err = 0.
- Memory bytes 0x10..0x13 = EF BE AD DE: LB 0x10 -> 0xFFFFFFEF; LBU -> 0x000000EF; LH -> 0xFFFFBEEF; LHU -> 0x0000BEEF; LW -> 0xDEADBEEF; each resp_valid 3 cycles after accept.
- SB addr 0x20 wdata 0x12345678 -> byte_enable 00, only 0x20 = 0x78 changes; SH -> 01, 0x20/0x21 = 78 56.
- funct3 = 011 load -> no mem_enable, resp_valid 1 cycle after accept, resp_err = 1, rdata 0; resp_ready held low 5 cycles -> outputs stable and req_ready = 0.
- LW addr 0x13: with MISALIGN_TRAP_EN -> resp_err = 1, no access; without -> mem_addr = 0x13, access made, resp_err = 0.
